// File: rtl/qdec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qdec_pkg
// Brief    : Shared types, parameter limits and helpers for the quad decoder.
// Revision : 1.0 - initial release
// ============================================================================

package qdec_pkg;

    typedef enum logic {
        RES_X1 = 1'b0,
        RES_X2 = 1'b1
    } qdec_res_e;

    localparam int c_NCH_MIN   = 1;
    localparam int c_NCH_MAX   = 8;
    localparam int c_CNT_W_MIN = 4;
    localparam int c_CNT_W_MAX = 16;
    localparam int c_SYNC_MIN  = 2;
    localparam int c_SYNC_MAX  = 3;

    // A single channel still needs a one-bit select so the port never collapses.
    function automatic int adr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int nch, input int cnt_w, input int sync);
        return (nch   >= c_NCH_MIN)   && (nch   <= c_NCH_MAX)   &&
               (cnt_w >= c_CNT_W_MIN) && (cnt_w <= c_CNT_W_MAX) &&
               (sync  >= c_SYNC_MIN)  && (sync  <= c_SYNC_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/qdec_channel.sv
`default_nettype none
// ============================================================================
// Module   : qdec_channel
// Brief    : One trackball channel: input synchronizers, edge detect and
//            signed position counter with sticky movement flag.
//            Define QDEC_SATURATE_EN to clamp the counter at its signed limits.
// Revision : 1.0 - initial release
// ============================================================================

module qdec_channel
    import qdec_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             GCLK,
    input  logic             reset_n,
    input  logic             i_qclk,
    input  logic             i_qdir,
    input  qdec_res_e        i_res_mode,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_moved
);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dir_sync;
    logic                   r_clk_hist;
    logic [CNT_W-1:0]       r_count;
    logic                   r_moved;

    logic                   w_clk_s;
    logic                   w_dir_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_event;
    logic [CNT_W-1:0]       w_base;
    logic [CNT_W-1:0]       w_next;

`ifdef QDEC_SATURATE_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] c_CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
`endif

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dir_s = r_dir_sync[SYNC_STAGES-1];
    assign w_rise  = w_clk_s & ~r_clk_hist;
    assign w_fall  = ~w_clk_s & r_clk_hist;
    assign w_event = w_rise | ((i_res_mode == RES_X2) & w_fall);

    // A clearing read in the event cycle restarts from zero, so the event still lands.
    always_comb begin
        w_base = i_clr ? '0 : r_count;
        w_next = w_base;
`ifdef QDEC_SATURATE_EN
        if (w_dir_s) begin
            if (w_base != c_CNT_MAX) w_next = w_base + CNT_W'(1);
        end else begin
            if (w_base != c_CNT_MIN) w_next = w_base - CNT_W'(1);
        end
`else
        if (w_dir_s) w_next = w_base + CNT_W'(1);
        else         w_next = w_base - CNT_W'(1);
`endif
    end

    always_ff @(posedge GCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync <= '0;
            r_dir_sync <= '0;
            r_clk_hist <= 1'b0;
            r_count    <= '0;
            r_moved    <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_qclk};
            r_dir_sync <= {r_dir_sync[SYNC_STAGES-2:0], i_qdir};
            r_clk_hist <= w_clk_s;

            if (w_event)    r_count <= w_next;
            else if (i_clr) r_count <= '0;

            // Clamped events still count as movement.
            if (w_event)    r_moved <= 1'b1;
            else if (i_clr) r_moved <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_moved = r_moved;

endmodule

`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder
// Brief    : Multi-channel trackball clock/direction decoder with a
//            single-port read/clear interface and movement interrupt.
//            Define QDEC_SATURATE_EN to clamp counters instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================

module quad_decoder
    import qdec_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        GCLK,
    input  logic                        reset_n,
    input  logic [NCH-1:0]              qclk,
    input  logic [NCH-1:0]              qdir,
    input  logic                        resoln,
    input  logic                        rd_req,
    input  logic [adr_width(NCH)-1:0]   rd_adr,
    input  logic                        rd_clr,
    output logic                        rd_ack,
    output logic [CNT_W-1:0]            rd_data,
    output logic [NCH-1:0]              moved,
    output logic                        irq
);

    localparam int ADR_W = adr_width(NCH);

    generate
        if (!params_ok(NCH, CNT_W, SYNC_STAGES)) begin : g_param_err
            $error("quad_decoder: NCH, CNT_W or SYNC_STAGES out of range");
        end
    endgenerate

    qdec_res_e          w_res_mode;
    logic [CNT_W-1:0]   w_count [NCH];
    logic [NCH-1:0]     w_clr;
    logic [CNT_W-1:0]   w_rd_sel;

    logic               r_rd_ack;
    logic [CNT_W-1:0]   r_rd_data;

    assign w_res_mode = qdec_res_e'(resoln);

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            assign w_clr[i] = rd_req & rd_clr & (rd_adr == ADR_W'(i));

            qdec_channel #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_channel (
                .GCLK       (GCLK),
                .reset_n    (reset_n),
                .i_qclk     (qclk[i]),
                .i_qdir     (qdir[i]),
                .i_res_mode (w_res_mode),
                .i_clr      (w_clr[i]),
                .o_count    (w_count[i]),
                .o_moved    (moved[i])
            );
        end
    endgenerate

    // Addresses beyond the last channel match nothing and read back as zero.
    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_adr == ADR_W'(i)) w_rd_sel = w_count[i];
        end
    end

    always_ff @(posedge GCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_ack <= rd_req;
            if (rd_req) r_rd_data <= w_rd_sel;
        end
    end

    assign rd_ack  = r_rd_ack;
    assign rd_data = r_rd_data;
    assign irq     = |moved;

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_decoder
// Brief    : Directed self-checking bench for quad_decoder (NCH=3, CNT_W=8).
// Revision : 1.0 - initial release
// ============================================================================

module tb_quad_decoder;

    localparam int NCH         = 3;
    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;

    logic             GCLK = 1'b0;
    logic             reset_n;
    logic [NCH-1:0]   qclk;
    logic [NCH-1:0]   qdir;
    logic             resoln;
    logic             rd_req;
    logic [1:0]       rd_adr;
    logic             rd_clr;
    logic             rd_ack;
    logic [CNT_W-1:0] rd_data;
    logic [NCH-1:0]   moved;
    logic             irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] r_data;
    logic       r_ack;
    logic [7:0] c_wrap_exp;

    quad_decoder #(
        .NCH         (NCH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .GCLK    (GCLK),
        .reset_n (reset_n),
        .qclk    (qclk),
        .qdir    (qdir),
        .resoln  (resoln),
        .rd_req  (rd_req),
        .rd_adr  (rd_adr),
        .rd_clr  (rd_clr),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .moved   (moved),
        .irq     (irq)
    );

    always #5 GCLK = ~GCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge GCLK);
        #1;
    endtask

    task automatic pulse(input int ch);
        qclk[ch] = 1'b1;
        tick(3);
        qclk[ch] = 1'b0;
        tick(3);
    endtask

    task automatic do_read(input logic [1:0] adr, input logic clr,
                           output logic [7:0] data, output logic ack);
        rd_req = 1'b1;
        rd_adr = adr;
        rd_clr = clr;
        tick();
        ack    = rd_ack;
        data   = rd_data;
        rd_req = 1'b0;
        rd_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef QDEC_SATURATE_EN
        c_wrap_exp = 8'h7F;
`else
        c_wrap_exp = 8'h80;
`endif
        reset_n = 1'b0;
        qclk    = '0;
        qdir    = '0;
        resoln  = 1'b0;
        rd_req  = 1'b0;
        rd_adr  = '0;
        rd_clr  = 1'b0;
        tick(3);
        check("reset_rd_ack",  rd_ack,  0);
        check("reset_rd_data", rd_data, 0);
        check("reset_moved",   moved,   0);
        check("reset_irq",     irq,     0);
        reset_n = 1'b1;
        tick(2);

        // x1 counting on ch0, first edge also measures latency
        qdir[0] = 1'b1;
        qclk[0] = 1'b1;
        tick(2);
        check("latency_early", moved[0], 0);
        tick(1);
        check("latency_hit", moved[0], 1);
        qclk[0] = 1'b0;
        tick(3);
        repeat (4) pulse(0);
        tick(2);
        do_read(2'd0, 1'b0, r_data, r_ack);
        check("x1_ack", r_ack, 1);
        check("x1_ch0", r_data, 8'h05);
        check("x1_moved0", moved[0], 1);
        tick();
        check("ack_single", rd_ack, 0);
        do_read(2'd0, 1'b0, r_data, r_ack);
        check("noclr_keep", r_data, 8'h05);

        // x2 counting down on ch2
        resoln  = 1'b1;
        qdir[2] = 1'b0;
        repeat (3) pulse(2);
        tick(2);
        do_read(2'd2, 1'b0, r_data, r_ack);
        check("x2_ch2", r_data, 8'hFA);
        check("moved_101", moved, 3'b101);
        check("irq_set", irq, 1);

        // build ch1 = 0x10, then clearing read coinciding with +1 event
        qdir[1] = 1'b1;
        repeat (8) pulse(1);
        tick(2);
        do_read(2'd1, 1'b0, r_data, r_ack);
        check("ch1_16", r_data, 8'h10);
        resoln  = 1'b0;
        qclk[1] = 1'b1;
        tick(2);
        do_read(2'd1, 1'b1, r_data, r_ack);
        check("coinc_ack", r_ack, 1);
        check("coinc_data", r_data, 8'h10);
        qclk[1] = 1'b0;
        tick(4);
        do_read(2'd1, 1'b0, r_data, r_ack);
        check("coinc_after", r_data, 8'h01);
        check("coinc_moved1", moved[1], 1);

        // plain clearing read of ch0
        do_read(2'd0, 1'b1, r_data, r_ack);
        check("clr_data", r_data, 8'h05);
        do_read(2'd0, 1'b0, r_data, r_ack);
        check("clr_zero", r_data, 8'h00);
        check("clr_moved", moved, 3'b110);

        // out-of-range address followed by back-to-back reads
        rd_req = 1'b1;
        rd_adr = 2'd3;
        tick();
        check("oor_ack", rd_ack, 1);
        check("oor_data", rd_data, 8'h00);
        rd_adr = 2'd2;
        tick();
        check("b2b_ack0", rd_ack, 1);
        check("b2b_ch2", rd_data, 8'hFA);
        rd_adr = 2'd1;
        tick();
        check("b2b_ack1", rd_ack, 1);
        check("b2b_ch1", rd_data, 8'h01);
        rd_req = 1'b0;
        tick();
        check("b2b_end", rd_ack, 0);
        check("oor_moved", moved, 3'b110);

        // ch0 to 0x7F, then one more +1
        resoln  = 1'b1;
        qdir[0] = 1'b1;
        repeat (63) pulse(0);
        resoln  = 1'b0;
        qclk[0] = 1'b1;
        tick(5);
        do_read(2'd0, 1'b0, r_data, r_ack);
        check("pos_max", r_data, 8'h7F);
        resoln  = 1'b1;
        qclk[0] = 1'b0;
        tick(5);
        do_read(2'd0, 1'b0, r_data, r_ack);
        check("wrap_or_sat", r_data, c_wrap_exp);
        check("sat_moved0", moved[0], 1);

        // reset during activity with a read in flight; qclk held high through reset
        qclk   = 3'b111;
        qdir   = 3'b111;
        tick();
        rd_req = 1'b1;
        rd_adr = 2'd2;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ack",   rd_ack,  0);
        check("arst_data",  rd_data, 0);
        check("arst_moved", moved,   0);
        check("arst_irq",   irq,     0);
        rd_req = 1'b0;
        tick(2);
        check("arst_hold_ack", rd_ack, 0);
        reset_n = 1'b1;
        tick();
        check("post_rst_ack", rd_ack, 0);
        tick(6);
        do_read(2'd0, 1'b0, r_data, r_ack);
        check("held_ch0", r_data, 8'h01);
        do_read(2'd1, 1'b0, r_data, r_ack);
        check("held_ch1", r_data, 8'h01);
        do_read(2'd2, 1'b0, r_data, r_ack);
        check("held_ch2", r_data, 8'h01);
        check("held_moved", moved, 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter NCH, default 4: number of trackball channels, each a clock/direction pair; legal range 1..8.
REQ-002 Parameter CNT_W, default 8: position counter width per channel; legal range 4..16.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer flops per input; legal range 2..3.
REQ-004 GCLK  in  1: single system clock; all logic on its rising edge.
REQ-005 reset_n  in  1: reset, asynchronous assert, active-low.
REQ-006 qclk  in  NCH: raw trackball clock lines, asynchronous to GCLK.
REQ-007 qdir  in  NCH: raw trackball direction lines, asynchronous to GCLK.
REQ-008 resoln  in  1: 0 = count on rising qclk edges only (x1); 1 = count on both edges (x2).
REQ-009 rd_req  in  1: read request, single-cycle pulse.
REQ-010 rd_adr  in  $clog2(NCH) (min 1): channel select, sampled with rd_req.
REQ-011 rd_clr  in  1: with rd_req, zero the selected counter after the read.
REQ-012 rd_ack  out  1: read data valid, one-cycle pulse.
REQ-013 rd_data  out  CNT_W: selected counter value, held until the next rd_ack.
REQ-014 moved  out  NCH: sticky per-channel flag, set by any count event.
REQ-015 irq  out  1: OR of moved.

Function
REQ-016 Each qclk and qdir bit SHALL pass through SYNC_STAGES flops before any use.
REQ-017 An edge SHALL be detected by comparing the last sync stage with one further history flop.
REQ-018 A count event SHALL be a synced qclk rising edge, or, when resoln=1, either synced qclk edge.
REQ-019 Direction SHALL be the synced qdir value in the event cycle: 1 = +1, 0 = -1.
REQ-020 Counters SHALL be two's-complement CNT_W bits and wrap modulo 2^CNT_W by default: 0x7F+1 = 0x80, 0x00-1 = 0xFF.
REQ-021 Latency from a raw qclk edge to the counter update SHALL be SYNC_STAGES+1 GCLK cycles.
REQ-022 rd_ack SHALL pulse exactly one cycle after rd_req, with rd_data equal to the counter value in the rd_req cycle.
REQ-023 rd_req with rd_adr >= NCH SHALL still produce rd_ack, with rd_data = 0 and no state change.
REQ-024 rd_req with rd_clr=1 SHALL set the counter to 0 and clear moved for that channel.
REQ-025 If a count event coincides with a clearing read of the same channel, the counter SHALL become the event's ±1 and moved SHALL remain set; the returned rd_data SHALL be the pre-event value.
REQ-026 rd_req without rd_clr SHALL leave the counter and moved unchanged.
REQ-027 A rd_req in the cycle of a pending rd_ack SHALL be accepted; back-to-back reads SHALL give one rd_ack per request.
REQ-028 Channels SHALL be fully independent; simultaneous events on every channel SHALL all be counted.

Reset
REQ-029 With reset_n low: all counters 0; moved 0; irq 0; rd_ack 0; rd_data 0; synchronizer and history flops 0.
REQ-030 After reset release, the first edge comparison SHALL treat history as 0, so a qclk held high through reset SHALL yield one rising event.
REQ-031 Reset asserted mid-read SHALL suppress the pending rd_ack.

Configuration
REQ-032 Macro QDEC_SATURATE_EN: when defined, counters SHALL clamp at the signed extremes (0x7F, 0x80 for CNT_W=8), ignoring further events in that direction; when undefined, counters wrap per REQ-020.
REQ-033 Saturation SHALL NOT affect moved, which sets on every event, clamped or not.

Structure
REQ-034 The package qdec_pkg SHALL hold the resolution-mode enum (RES_X1, RES_X2) and the parameter range-check constants.
REQ-035 The sub-module qdec_channel SHALL contain the synchronizer, edge detect and counter for one channel, instantiated NCH times by generate.
REQ-036 The read mux and rd_ack register SHALL reside in quad_decoder.

Verification
REQ-037 Reset, then 5 qclk rising edges on ch0 with qdir=1 and resoln=0, then a read of ch0 -> rd_data=0x05 and moved[0]=1.
REQ-038 resoln=1, 3 full qclk pulses on ch2 with qdir=0 -> ch2 counter 0xFA.
REQ-039 Starting from 0x7F, one +1 event -> 0x80 when the macro is undefined, 0x7F when QDEC_SATURATE_EN is defined.
REQ-040 A clearing read of ch1 (value 0x10) in the same cycle as a +1 event on ch1 -> rd_data=0x10, counter afterwards 0x01, moved[1]=1.
REQ-041 rd_req with rd_adr=NCH (NCH=3) -> rd_ack after 1 cycle, rd_data=0, all counters unchanged.
REQ-042 reset_n pulsed low during active counting on all channels -> all outputs 0 within the same cycle; no rd_ack is issued for an in-flight read.
